// File: rtl/neo_sched_pkg.sv
// Shared defaults and types for the NEO channel scheduler.
package neo_sched_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 16;
  localparam int DP_LAT_DEF = 3;
  localparam int CH_W_DEF   = $clog2(NUM_CH_DEF);

  // Channel index at the default channel count.
  typedef logic [CH_W_DEF-1:0] ch_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after
// the pointer (wrapping) and reports the pointer value that follows it.
module rr_arbiter
  import neo_sched_pkg::*;
#(
  parameter int N  = NUM_CH_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic [IW-1:0] next_ptr
);

  // Scan requests starting at ptr; the first hit wins.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path through the block leaves a value held (no latch).
    sum       = '0;
    idx       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr and k are both below N, so one subtraction is enough to wrap.
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  // Advance past the granted channel; hold the pointer when idle.
  always_comb begin
    next_ptr = ptr;
    if (gnt_valid) begin
      next_ptr = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/neo_channel_scheduler.sv
// Shares one NEO spike-detection datapath across NUM_CH channels: one-entry
// buffer per channel, round-robin issue, and a tag pipeline that pairs each
// datapath result with the channel it came from.
module neo_channel_scheduler
  import neo_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int DP_LAT = DP_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH-1:0]        ch_strobe,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        drop_clear,
  output logic [NUM_CH-1:0]        drop_flag,
  output logic                     dp_valid,
  output logic [DATA_W-1:0]        dp_data,
  output logic [CH_W-1:0]          dp_ch,
  input  logic                     dp_spike,
  output logic                     evt_valid,
  output logic [CH_W-1:0]          evt_ch,
  output logic                     evt_spike
);

  logic [NUM_CH-1:0] buf_full;
  logic [DATA_W-1:0] buf_data [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;

  logic              gnt_valid;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   next_ptr;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt_onehot;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drop;

  logic [DP_LAT-1:0] tag_valid;
  logic [CH_W-1:0]   tag_ch [DP_LAT];

  // A buffer on a channel being disabled is never issued, even in the cycle
  // before its contents are flushed.
  assign req = buf_full & ch_enable;

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (CH_W)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .next_ptr  (next_ptr)
  );

  // Expand the granted index to a per-channel mask.
  always_comb begin
    gnt_onehot = '0;
    if (gnt_valid) gnt_onehot[gnt_idx] = 1'b1;
  end

  // A strobe loads when the buffer is empty or is being drained this cycle;
  // otherwise the new sample is the one that is lost.
  assign load = ch_enable & ch_strobe & (~buf_full | gnt_onehot);
  assign drop = ch_enable & ch_strobe & buf_full & ~gnt_onehot;

  // Buffer occupancy and sticky drop flags; a new drop beats a clear.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      buf_full  <= '0;
      drop_flag <= '0;
    end else begin
      buf_full  <= ch_enable & (load | (buf_full & ~gnt_onehot));
      drop_flag <= drop | (drop_flag & ~drop_clear);
    end
  end

  // Buffer payload storage.
  // NOTE: payload is deliberately not reset; buf_full qualifies it, so
  // the data array needs no reset network.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (load[i]) buf_data[i] <= ch_data[i*DATA_W +: DATA_W];
    end
  end

  // Registered issue to the datapath and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_data  <= '0;
      dp_ch    <= '0;
      rr_ptr   <= '0;
    end else begin
      dp_valid <= gnt_valid;
      rr_ptr   <= next_ptr;
      if (gnt_valid) begin
        dp_data <= buf_data[gnt_idx];
        dp_ch   <= gnt_idx;
      end
    end
  end

  // Tag shift register tracking in-flight samples through the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      for (int k = 0; k < DP_LAT; k++) tag_ch[k] <= '0;
    end else begin
      tag_valid[0] <= dp_valid;
      tag_ch[0]    <= dp_ch;
      for (int k = 1; k < DP_LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_ch[k]    <= tag_ch[k-1];
      end
    end
  end

  // Tagged event output; a result with no matching tag is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_spike <= 1'b0;
    end else begin
      evt_valid <= tag_valid[DP_LAT-1];
      evt_ch    <= tag_ch[DP_LAT-1];
      evt_spike <= dp_spike & tag_valid[DP_LAT-1];
    end
  end

endmodule

// File: tb/tb_neo_channel_scheduler.sv
// Directed self-checking bench for neo_channel_scheduler (4 channels,
// 16-bit data, datapath latency 3).
module tb_neo_channel_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int CW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  ch_enable;
  logic [NCH-1:0]  ch_strobe;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]  drop_clear;
  logic [NCH-1:0]  drop_flag;
  logic            dp_valid;
  logic [DW-1:0]   dp_data;
  logic [CW-1:0]   dp_ch;
  logic            dp_spike;
  logic            evt_valid;
  logic [CW-1:0]   evt_ch;
  logic            evt_spike;

  int checks   = 0;
  int failures = 0;

  neo_channel_scheduler #(
    .NUM_CH (NCH),
    .DATA_W (DW),
    .CH_W   (CW),
    .DP_LAT (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_enable  (ch_enable),
    .ch_strobe  (ch_strobe),
    .ch_data    (ch_data),
    .drop_clear (drop_clear),
    .drop_flag  (drop_flag),
    .dp_valid   (dp_valid),
    .dp_data    (dp_data),
    .dp_ch      (dp_ch),
    .dp_spike   (dp_spike),
    .evt_valid  (evt_valid),
    .evt_ch     (evt_ch),
    .evt_spike  (evt_spike)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    ch_data[ch*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    ch_strobe  = '0;
    drop_clear = '0;
    dp_spike   = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dp_valid"},  32'(dp_valid),  0);
    check({tag, "_dp_data"},   32'(dp_data),   0);
    check({tag, "_dp_ch"},     32'(dp_ch),     0);
    check({tag, "_evt_valid"}, 32'(evt_valid), 0);
    check({tag, "_evt_ch"},    32'(evt_ch),    0);
    check({tag, "_evt_spike"}, 32'(evt_spike), 0);
    check({tag, "_drop_flag"}, 32'(drop_flag), 0);
  endtask

  initial begin
    rst        = 1'b1;
    ch_enable  = '1;
    ch_strobe  = '0;
    ch_data    = '0;
    drop_clear = '0;
    dp_spike   = 1'b0;
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // ---- Single channel: ch2, 0x1234 ----
    set_data(2, 16'h1234);
    ch_strobe = 4'b0100;
    tick();
    ch_strobe = '0;
    check("single_t1_dp_valid", 32'(dp_valid), 0);
    tick();
    check("single_dp_valid", 32'(dp_valid), 1);
    check("single_dp_ch",    32'(dp_ch),    2);
    check("single_dp_data",  32'(dp_data),  32'h1234);
    tick();
    check("single_dp_valid_gone", 32'(dp_valid), 0);
    tick();
    tick();
    dp_spike = 1'b1;
    check("single_evt_early", 32'(evt_valid), 0);
    tick();
    dp_spike = 1'b0;
    check("single_evt_valid", 32'(evt_valid), 1);
    check("single_evt_ch",    32'(evt_ch),    2);
    check("single_evt_spike", 32'(evt_spike), 1);
    tick();
    check("single_evt_gone", 32'(evt_valid), 0);

    // ---- Fairness: two back-to-back rounds of 0,1,2,3 ----
    do_reset();
    for (int i = 0; i < NCH; i++) set_data(i, 16'(32'hA000 + i));
    ch_strobe = '1;
    tick();
    ch_strobe = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_dp_valid", 32'(dp_valid), 1);
      check("rr_dp_ch",    32'(dp_ch),    k % 4);
      check("rr_dp_data",  32'(dp_data),  ((k < 4) ? 32'hA000 : 32'hB000) + (k % 4));
      if (k == 2) begin
        for (int i = 0; i < NCH; i++) set_data(i, 16'(32'hB000 + i));
        ch_strobe = '1;
      end else begin
        ch_strobe = '0;
      end
    end
    check("rr_drop_flag", 32'(drop_flag), 0);
    tick();
    check("rr_idle", 32'(dp_valid), 0);

    // ---- Drop: ch1 strobed twice while ch0 holds the grant ----
    do_reset();
    set_data(0, 16'h0100);
    set_data(1, 16'h1111);
    ch_strobe = 4'b0011;
    tick();
    set_data(1, 16'h2222);
    ch_strobe  = 4'b0010;
    drop_clear = 4'b0010;   // clear coincides with the drop; the drop wins
    tick();
    ch_strobe  = '0;
    drop_clear = '0;
    check("drop_dp_ch0",  32'(dp_ch),     0);
    check("drop_flag_set", 32'(drop_flag), 32'h2);
    tick();
    check("drop_dp_valid", 32'(dp_valid), 1);
    check("drop_dp_ch1",   32'(dp_ch),    1);
    check("drop_dp_data",  32'(dp_data),  32'h1111);
    check("drop_flag_held", 32'(drop_flag), 32'h2);
    drop_clear = 4'b0010;
    tick();
    drop_clear = '0;
    check("drop_flag_clr", 32'(drop_flag), 0);
    check("drop_no_reissue", 32'(dp_valid), 0);

    // ---- Same-cycle load/grant: ch3 strobed every cycle ----
    do_reset();
    ch_enable = 4'b1000;
    for (int n = 0; n <= 6; n++) begin
      if (n < 6) begin
        set_data(3, 16'(32'h3000 + n));
        ch_strobe = 4'b1000;
      end else begin
        ch_strobe = '0;
      end
      tick();
      if (n >= 1) begin
        check("stream_dp_valid", 32'(dp_valid), 1);
        check("stream_dp_ch",    32'(dp_ch),    3);
        check("stream_dp_data",  32'(dp_data),  32'h3000 + n - 1);
      end
    end
    check("stream_drop_flag", 32'(drop_flag), 0);

    // ---- Disable: filled ch0 is flushed, later strobes ignored ----
    do_reset();
    ch_enable = '1;
    set_data(0, 16'h0AAA);
    ch_strobe = 4'b0001;
    tick();
    ch_strobe = '0;
    ch_enable = 4'b1110;
    tick();
    check("dis_no_issue", 32'(dp_valid), 0);
    ch_strobe = 4'b0001;
    tick();
    ch_strobe = '0;
    tick();
    check("dis_strobe_ignored", 32'(dp_valid), 0);
    ch_enable = '1;
    tick();
    check("dis_reenable_empty", 32'(dp_valid), 0);
    tick();
    check("dis_reenable_empty2", 32'(dp_valid), 0);

    // ---- Reset mid-flight ----
    set_data(1, 16'h5555);
    ch_strobe = 4'b0010;
    tick();
    ch_strobe = '0;
    tick();
    check("mid_dp_valid", 32'(dp_valid), 1);
    tick();
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    dp_spike = 1'b1;
    check_all_zero("mid_rst");
    for (int k = 0; k < 5; k++) begin
      tick();
      check("mid_evt_valid", 32'(evt_valid), 0);
      check("mid_evt_spike", 32'(evt_spike), 0);
    end
    dp_spike = 1'b0;
    check_all_zero("mid_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neo_channel_scheduler.md
# neo_channel_scheduler

Time-multiplexes one shared NEO spike-detection datapath across `NUM_CH` electrode channels. Each channel delivers ADC samples as single-cycle strobes into a one-entry holding buffer. A round-robin arbiter issues one buffered sample per cycle to the datapath, tagged with its channel index. The detection result returned after a fixed latency is re-associated with that channel and emitted as a tagged event toward the event classifier.

## Interface
Parameters:
- `NUM_CH`, 4: number of electrode channels, 2..16.
- `DATA_W`, 16: sample width.
- `CH_W`, `$clog2(NUM_CH)`: channel index width.
- `DP_LAT`, 3: datapath latency in cycles, from `dp_valid` to `dp_spike`; minimum 1.

Ports (clock and reset first):
- `clk`  in  1: single clock; every register is clocked on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ch_enable`  in  `NUM_CH`: per-channel enable.
- `ch_strobe`  in  `NUM_CH`: new sample on channel i this cycle.
- `ch_data`  in  `NUM_CH*DATA_W`: channel i occupies bits `[i*DATA_W +: DATA_W]`.
- `drop_clear`  in  `NUM_CH`: clears the matching `drop_flag` bits.
- `drop_flag`  out  `NUM_CH`: sticky flag; set when a sample was lost on that channel.
- `dp_valid`  out  1: sample issued to the datapath.
- `dp_data`  out  `DATA_W`: issued sample.
- `dp_ch`  out  `CH_W`: issued channel; the datapath uses it to select per-channel context.
- `dp_spike`  in  1: datapath result, valid exactly `DP_LAT` cycles after the matching `dp_valid`.
- `evt_valid`  out  1: tagged result valid.
- `evt_ch`  out  `CH_W`: channel of the result.
- `evt_spike`  out  1: spike detected.

## Operation
- Per channel: `buf_full`, `buf_data`. A strobe on a disabled channel is ignored.
- Load: an enabled strobe with an empty buffer loads the data and sets `buf_full`.
- Arbitration: each cycle, among channels with `buf_full=1`, grant the first at or after `rr_ptr` (wrapping). On grant:
  - register the sample to `dp_*`;
  - clear that buffer;
  - set `rr_ptr` to granted+1, modulo `NUM_CH`.
  - With no full buffer: `dp_valid=0` and `rr_ptr` holds.
- Strobe in the same cycle as a grant of that channel: the new sample loads and the buffer stays full. No drop.
- Strobe while full and not granted: keep the old sample, discard the new one, set `drop_flag[i]`.
- `drop_clear[i]` in the same cycle as a new drop: set wins.
- Deasserting `ch_enable[i]`: clears `buf_full[i]` on the next edge. Samples already issued still complete.
- Tag pipeline: a `DP_LAT`-deep shift register of `{valid, ch}` fed from `dp_valid`/`dp_ch`.
  - At its output stage: `evt_valid <= tag_valid`, `evt_ch <= tag_ch`, `evt_spike <= dp_spike & tag_valid`.
  - `dp_spike` is ignored when no tag is valid.
- Reset:
  - all buffers empty, `rr_ptr=0`, tag pipeline cleared;
  - all outputs 0: `dp_valid`, `dp_data`, `dp_ch`, `evt_*`, `drop_flag`.
- Reset mid-operation discards in-flight tags. Datapath results arriving after reset produce no events.

## Timing
- Strobe in cycle t into an empty buffer → `buf_full` in t+1. Earliest `dp_valid` is t+2 (arbitration in t+1, registered output).
- `dp_valid` in cycle u → `evt_valid` in cycle u+`DP_LAT`+1.
- Throughput: one issue per cycle. Sustained input of up to one strobe per cycle summed across channels is lossless.
- With all `NUM_CH` buffers full, each channel is granted once every `NUM_CH` cycles (strict rotation).
- No combinational path from any input to any output.

## Structure
- Package `neo_sched_pkg`: default constants for `NUM_CH`, `DATA_W`, `DP_LAT`, and a `ch_idx_t` typedef.
- Sub-module `rr_arbiter` (`NUM_CH` requests in; grant index, grant-valid and pointer update out), reusable elsewhere.
- The tag shift register stays inline.

## Test plan
- Single channel: reset, then strobe ch2 with data 0x1234 at t0 → `dp_valid`, `dp_ch=2`, `dp_data=0x1234` at t0+2. With `dp_spike=1` returned at the right cycle → `evt_valid=1`, `evt_ch=2`, `evt_spike=1` at t0+2+`DP_LAT`+1.
- Fairness: all 4 channels strobed in the same cycle → grants 0,1,2,3 on consecutive cycles. Refill all 4 immediately after the last grant (`rr_ptr=0`) → the next round is 0,1,2,3 again. No drops.
- Drop: ch1 strobed on two consecutive cycles while ch0 holds the grant → the first sample is issued, the second is discarded and `drop_flag[1]=1`. `drop_clear[1]` → flag returns to 0 next cycle.
- Same-cycle load/grant: ch3 strobed every cycle with only ch3 enabled → one issue per cycle, data in order, `drop_flag=0`.
- Disable: fill ch0, then deassert `ch_enable[0]` before it is granted → no issue for ch0. Later strobes on ch0 are ignored.
- Reset mid-flight: assert `rst` one cycle after a `dp_valid`, then drive `dp_spike=1` → `evt_valid` stays 0 and all outputs are 0 after reset.
